reg_file_wb_sink: RTL and testbench
===================================

Name: reg_file_wb_sink

Overview:
- Write-back consumer of the MIPS datapath: the register file that accepts the WB stage's write_data/reg_write pair and serves ID-stage reads.
- Two combinational read ports with write-through bypass.
- Per-register pending-write scoreboard; ID uses its busy flags to stall on RAW hazards until the producing instruction retires through WB.

Parameters:
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width; must equal $clog2(NUM_REGS).
- CNT_W, 2, width of each per-register pending counter; maximum in-flight writers per register = 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb_reg_write  input  1  write enable from WB stage (reg_write).
- wb_addr  input  ADDR_W  destination register of retiring instruction.
- wb_data  input  DATA_W  write-back value (write_data).
- wb_retire  input  1  retiring instruction was counted at issue; decrements counter for wb_addr.
- issue_valid  input  1  ID issues an instruction this cycle with a tracked destination.
- issue_rd  input  ADDR_W  destination of issuing instruction.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- rs_busy  output  1  pending writer exists for rs_addr.
- rt_busy  output  1  pending writer exists for rt_addr.
- sb_overflow  output  1  sticky error: issue to a saturated counter.

Behaviour:
- Reset (async, rst=1): all registers 0, all counters 0, sb_overflow 0. Consequently rs/rt_data = 0 and rs/rt_busy = 0 while rst is held.
- Write:
  - On posedge clk, if wb_reg_write and wb_addr != 0, then reg[wb_addr] <= wb_data.
  - Writes to register 0 are discarded.
- Read (combinational, zero latency):
  - rs_data = 0 if rs_addr == 0.
  - Otherwise rs_data = wb_data if wb_reg_write and wb_addr == rs_addr (write-through bypass, same-cycle visibility).
  - Otherwise rs_data = reg[rs_addr].
  - rt_data follows the same rules using rt_addr.
- Scoreboard (counter cnt[r] per register, r = 1..NUM_REGS-1; cnt[0] is constant 0):
  - inc = issue_valid and issue_rd == r and issue_rd != 0.
  - dec = wb_retire and wb_addr == r.
  - inc and dec both set: cnt unchanged.
  - inc only: cnt+1. If cnt is at max, cnt holds and sb_overflow is set.
  - dec only: cnt-1. If cnt == 0, cnt holds at 0 (no underflow wrap).
  - wb_retire is independent of wb_reg_write: a squashed instruction retires with wb_reg_write=0 and wb_retire=1.
- Busy (combinational):
  - rs_busy = (rs_addr != 0) and (cnt[rs_addr] minus pending same-cycle dec for rs_addr) != 0.
  - A value retiring this cycle is therefore bypassed and not stalled on.
  - Same-cycle issue to rs_addr does not raise rs_busy until the next cycle.
  - rt_busy follows the same rules using rt_addr.
- sb_overflow stays set until reset.
- Reset mid-operation: all state clears immediately, independent of the clock. In-flight retires arriving after reset deassertion hit zero counters and saturate at 0.

Decomposition:
- Shared package (mips_pkg): DATA_W and ADDR_W constants, and a REG_ZERO = 0 constant.
- One natural sub-module: sb_counter, a single saturating up/down counter with overflow flag. Instantiate it NUM_REGS-1 times via generate.
- Storage array, bypass muxes and busy muxes stay in the top level.

Test Plan:
- Reset value: assert rst asynchronously mid-cycle, with reg 5 previously written to 0xDEADBEEF -> rs_data(5)=0 and rs_busy=0 before the next edge; sb_overflow=0.
- Bypass:
  - wb_reg_write=1, wb_addr=7, wb_data=0x12345678, rs_addr=7 -> rs_data=0x12345678 in the same cycle.
  - Next cycle with wb_reg_write=0 -> rs_data=0x12345678 from storage.
- Register 0: write 0xFFFFFFFF to addr 0, with issue_valid to rd 0 -> rs_data(0)=0 and rs_busy(0)=0 on every cycle.
- Scoreboard retire:
  - Issue rd=3 twice on consecutive cycles -> rt_busy(3)=1.
  - Retire once -> rt_busy still 1.
  - On the second retire cycle (wb_reg_write=1, data 0xA5) -> rt_busy=0 and rt_data=0xA5 in that same cycle.
- Simultaneous inc/dec: with cnt[4]=1, issue rd=4 and retire addr 4 in the same cycle -> cnt stays 1, rs_busy(4)=1 next cycle.
- Saturation/overflow (CNT_W=2):
  - Issue rd=9 four times -> sb_overflow=1 after the 4th edge.
  - Three retires -> busy(9)=0.
  - A 4th retire -> counter stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Datapath-wide constants shared by the register file and its scoreboard.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_file_wb_sink_if.sv
// Bundle of WB write/retire, ID issue and ID read-port signals for the register file.
interface reg_file_wb_sink_if #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W
);
    logic              wb_reg_write;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_retire;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              rs_busy;
    logic              rt_busy;
    logic              sb_overflow;

    modport master (
        output wb_reg_write, wb_addr, wb_data, wb_retire,
        output issue_valid, issue_rd, rs_addr, rt_addr,
        input  rs_data, rt_data, rs_busy, rt_busy, sb_overflow
    );

    modport slave (
        input  wb_reg_write, wb_addr, wb_data, wb_retire,
        input  issue_valid, issue_rd, rs_addr, rt_addr,
        output rs_data, rt_data, rs_busy, rt_busy, sb_overflow
    );
endinterface

// File: rtl/sb_counter.sv
// Saturating up/down pending-writer counter for one register, with sticky overflow flag.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             overflow
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            unique case ({inc, dec})
                2'b10: begin
                    if (cnt == '1) overflow <= 1'b1;
                    else           cnt      <= cnt + 1'b1;
                end
                2'b01: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_wb_sink.sv
// MIPS register file fed by WB: two bypassed read ports plus a per-register pending-write scoreboard.
module reg_file_wb_sink
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = mips_pkg::DATA_W,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
    parameter int unsigned CNT_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    reg_file_wb_sink_if.slave  bus
);

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [CNT_W-1:0]  cnt      [NUM_REGS];
    logic [NUM_REGS-1:0] ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (bus.wb_reg_write && bus.wb_addr != REG_ZERO) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign cnt[0] = '0;
    assign ovf[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (bus.issue_valid && bus.issue_rd == ADDR_W'(r)),
            .dec      (bus.wb_retire && bus.wb_addr == ADDR_W'(r)),
            .cnt      (cnt[r]),
            .overflow (ovf[r])
        );
    end

    assign bus.sb_overflow = |ovf;

    // A retire in flight this cycle clears the hazard: its value reaches ID through the bypass.
    logic rs_dec, rt_dec;
    assign rs_dec = bus.wb_retire && bus.wb_addr == bus.rs_addr;
    assign rt_dec = bus.wb_retire && bus.wb_addr == bus.rt_addr;

    assign bus.rs_busy = (bus.rs_addr != REG_ZERO) && (cnt[bus.rs_addr] > CNT_W'(rs_dec));
    assign bus.rt_busy = (bus.rt_addr != REG_ZERO) && (cnt[bus.rt_addr] > CNT_W'(rt_dec));

    always_comb begin
        bus.rs_data = regs[bus.rs_addr];
        if (bus.rs_addr == REG_ZERO)
            bus.rs_data = '0;
        else if (bus.wb_reg_write && bus.wb_addr == bus.rs_addr)
            bus.rs_data = bus.wb_data;
    end

    always_comb begin
        bus.rt_data = regs[bus.rt_addr];
        if (bus.rt_addr == REG_ZERO)
            bus.rt_data = '0;
        else if (bus.wb_reg_write && bus.wb_addr == bus.rt_addr)
            bus.rt_data = bus.wb_data;
    end

endmodule

// File: tb/tb_reg_file_wb_sink.sv
// Directed bench for reg_file_wb_sink: bypass, r0, scoreboard retire/saturation and async reset.
module tb_reg_file_wb_sink;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_wb_sink_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_wb_sink #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .ADDR_W   (5),
        .CNT_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change there, checks follow 2ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_reg_write = 1'b0;
        bus.wb_addr      = '0;
        bus.wb_data      = '0;
        bus.wb_retire    = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_rd     = '0;
    endtask

    initial begin
        idle();
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        bus.rs_addr = 5'd5;
        #2;
        check("init_rs_data", bus.rs_data, 32'h0);
        check("init_rs_busy", 32'(bus.rs_busy), 32'h0);
        check("init_ovf", 32'(bus.sb_overflow), 32'h0);

        // Bypass then storage
        next_cycle();
        bus.wb_reg_write = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h1234_5678;
        bus.rs_addr = 5'd7;
        #2 check("bypass_same_cycle", bus.rs_data, 32'h1234_5678);
        next_cycle();
        idle();
        #2 check("bypass_from_storage", bus.rs_data, 32'h1234_5678);

        // Register 0 ignores writes and issues
        next_cycle();
        bus.wb_reg_write = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rs_addr = 5'd0;
        #2;
        check("r0_data_c0", bus.rs_data, 32'h0);
        check("r0_busy_c0", 32'(bus.rs_busy), 32'h0);
        next_cycle();
        #2;
        check("r0_data_c1", bus.rs_data, 32'h0);
        check("r0_busy_c1", 32'(bus.rs_busy), 32'h0);
        next_cycle();
        idle();
        #2;
        check("r0_data_c2", bus.rs_data, 32'h0);
        check("r0_busy_c2", 32'(bus.rs_busy), 32'h0);

        // Scoreboard retire on r3
        next_cycle();
        bus.rt_addr = 5'd3; bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        #2 check("r3_busy_issue_cycle", 32'(bus.rt_busy), 32'h0);
        next_cycle();
        next_cycle();
        idle();
        #2 check("r3_busy_cnt2", 32'(bus.rt_busy), 32'h1);
        next_cycle();
        bus.wb_retire = 1'b1; bus.wb_addr = 5'd3;
        #2 check("r3_busy_retire1", 32'(bus.rt_busy), 32'h1);
        next_cycle();
        bus.wb_reg_write = 1'b1; bus.wb_data = 32'h0000_00A5;
        #2;
        check("r3_busy_retire2", 32'(bus.rt_busy), 32'h0);
        check("r3_data_retire2", bus.rt_data, 32'h0000_00A5);
        next_cycle();
        idle();
        #2;
        check("r3_busy_after", 32'(bus.rt_busy), 32'h0);
        check("r3_data_after", bus.rt_data, 32'h0000_00A5);

        // Simultaneous inc/dec on r4
        bus.rs_addr = 5'd4; bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        next_cycle();
        bus.wb_retire = 1'b1; bus.wb_addr = 5'd4;
        #2 check("r4_busy_incdec_cycle", 32'(bus.rs_busy), 32'h0);
        next_cycle();
        idle();
        #2 check("r4_busy_after_incdec", 32'(bus.rs_busy), 32'h1);
        bus.wb_retire = 1'b1; bus.wb_addr = 5'd4;
        next_cycle();
        idle();
        #2 check("r4_busy_drained", 32'(bus.rs_busy), 32'h0);

        // Saturation and overflow on r9
        bus.rs_addr = 5'd9; bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        next_cycle();
        next_cycle();
        next_cycle();
        #2 check("r9_ovf_after3", 32'(bus.sb_overflow), 32'h0);
        next_cycle();
        idle();
        #2;
        check("r9_ovf_after4", 32'(bus.sb_overflow), 32'h1);
        check("r9_busy_sat", 32'(bus.rs_busy), 32'h1);
        bus.wb_retire = 1'b1; bus.wb_addr = 5'd9;
        next_cycle();
        next_cycle();
        #2 check("r9_busy_cnt1_retiring", 32'(bus.rs_busy), 32'h0);
        next_cycle();
        next_cycle();
        idle();
        #2;
        check("r9_busy_no_wrap", 32'(bus.rs_busy), 32'h0);
        check("r9_ovf_sticky", 32'(bus.sb_overflow), 32'h1);

        // Async reset mid-cycle with r5 written and pending
        bus.wb_reg_write = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        next_cycle();
        idle();
        bus.rs_addr = 5'd5;
        #2;
        check("r5_data_pre_rst", bus.rs_data, 32'hDEAD_BEEF);
        check("r5_busy_pre_rst", 32'(bus.rs_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_rs_data", bus.rs_data, 32'h0);
        check("rst_rs_busy", 32'(bus.rs_busy), 32'h0);
        check("rst_ovf", 32'(bus.sb_overflow), 32'h0);
        next_cycle();
        rst = 1'b0;
        bus.wb_retire = 1'b1; bus.wb_addr = 5'd5;
        next_cycle();
        idle();
        #2;
        check("post_rst_retire_busy", 32'(bus.rs_busy), 32'h0);
        check("post_rst_data", bus.rs_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
